// File: rtl/cpu_pkg.sv
// cpu_pkg: shared ALU opcodes, flag struct and multiplier state type
package cpu_pkg;
   localparam logic [2:0] ALU_PASSB = 3'b000;
   localparam logic [2:0] ALU_MUL   = 3'b001;
   localparam logic [2:0] ALU_ADD   = 3'b010;
   localparam logic [2:0] ALU_SUB   = 3'b011;
   localparam logic [2:0] ALU_AND   = 3'b100;
   localparam logic [2:0] ALU_OR    = 3'b101;
   localparam logic [2:0] ALU_XOR   = 3'b110;
   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flags_t;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;
endpackage

// File: rtl/ex_stage_alu_64.sv
// alu_64: combinational ALU result and NZCV; unlisted opcodes pass operand b
module alu_64 import cpu_pkg::*; #(
   parameter int DW = 64
) (
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic [2:0]    op,
   output logic [DW-1:0] y,
   output flags_t        f
);
   logic          sub, arith;
   logic [DW-1:0] bb;
   logic [DW:0]   sum;
   // subtraction is a + ~b + 1 so carry and overflow share the adder path
   always_comb begin
      sub   = op == ALU_SUB;
      arith = sub || op == ALU_ADD;
      bb    = sub ? ~b : b;
      sum   = {1'b0, a} + {1'b0, bb} + {{DW{1'b0}}, sub};
      y     = arith ? sum[DW-1:0] : op == ALU_AND ? a & b : op == ALU_OR ? a | b : op == ALU_XOR ? a ^ b : b;
      f.n   = y[DW-1];
      f.z   = y == '0;
      f.c   = arith & sum[DW];
      f.v   = arith & (a[DW-1] == bb[DW-1]) & (y[DW-1] != a[DW-1]);
   end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: forwarding, ALU, flags, branch resolve, EX/MEM register; EX_MUL_EN adds iterative multiplier
module ex_stage import cpu_pkg::*; #(
   parameter int DW         = 64,
   parameter int MUL_CYCLES = 64
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [DW-1:0] Da_ex,
   input  logic [DW-1:0] Db_ex,
   input  logic [DW-1:0] BR_to_shift_ex,
   input  logic [DW-1:0] pc_ex,
   input  logic [DW-1:0] ALU_or_DT_ex,
   input  logic [4:0]    Rd_ex,
   input  logic [4:0]    Ab_ex,
   input  logic [4:0]    Rn_ex,
   input  logic [3:0]    xfer_size_ex,
   input  logic [2:0]    ALUop_ex,
   input  logic          cond_ex,
   input  logic          ALUsrc_ex,
   input  logic          MemtoReg_ex,
   input  logic          RegWrite_ex,
   input  logic          MemWrite_ex,
   input  logic          cbz_ex,
   input  logic          branch_ex,
   input  logic          BRsignal_ex,
   input  logic          update_ex,
   input  logic [DW-1:0] wr_data_wb,
   input  logic [4:0]    Rd_wb,
   input  logic          RegWrite_wb,
   output logic [DW-1:0] alu_mem,
   output logic [DW-1:0] wdata_mem,
   output logic [4:0]    Rd_mem,
   output logic [3:0]    xfer_size_mem,
   output logic          MemtoReg_mem,
   output logic          RegWrite_mem,
   output logic          MemWrite_mem,
   output logic          br_taken,
   output logic          flush,
   output logic [DW-1:0] br_target,
   output logic          stall
);
   logic [DW-1:0] fwd_a, fwd_b, op_b, alu_y, res;
   logic          mul_op;
   flags_t        alu_f, flags_q;

   assign fwd_a = (RegWrite_mem && Rd_mem == Rn_ex && Rd_mem != 5'd31) ? alu_mem :
                  (RegWrite_wb && Rd_wb == Rn_ex && Rd_wb != 5'd31) ? wr_data_wb : Da_ex;
   assign fwd_b = (RegWrite_mem && Rd_mem == Ab_ex && Rd_mem != 5'd31) ? alu_mem :
                  (RegWrite_wb && Rd_wb == Ab_ex && Rd_wb != 5'd31) ? wr_data_wb : Db_ex;
   assign op_b  = ALUsrc_ex ? ALU_or_DT_ex : fwd_b;

   alu_64 #(.DW(DW)) u_alu (.a(fwd_a), .b(op_b), .op(ALUop_ex), .y(alu_y), .f(alu_f));

`ifdef EX_MUL_EN
   localparam int CW = $clog2(MUL_CYCLES) + 1;
   mul_state_t    state;
   logic [DW-1:0] mcand, mplier, acc;
   logic [CW-1:0] cnt;
   assign mul_op = ALUop_ex == ALU_MUL;
   assign stall  = state == BUSY || (state == IDLE && mul_op);
   assign res    = state == DONE ? acc : alu_y;
   // shift-add multiplier: latch operands in IDLE, one multiplier bit per BUSY cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
      end else if (state == IDLE && mul_op) begin
         mcand  <= fwd_a;
         mplier <= op_b;
         acc    <= '0;
         cnt    <= '0;
         state  <= BUSY;
      end else if (state == BUSY) begin
         acc    <= mplier[0] ? acc + mcand : acc;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 1'b1;
         state  <= cnt == CW'(MUL_CYCLES - 1) ? DONE : BUSY;
      end else if (state == DONE) begin
         state  <= IDLE;
      end
   end
`else
   assign mul_op = 1'b0;
   assign stall  = 1'b0;
   assign res    = alu_y;
`endif

   // NZCV only commits for a flag-setting instruction that actually leaves EX
   always_ff @(posedge clk) begin
      if (reset) flags_q <= '0;
      else if (update_ex && !stall && !mul_op) flags_q <= alu_f;
   end

   assign br_taken  = branch_ex & (cbz_ex ? fwd_b == '0 : cond_ex ? flags_q.n != flags_q.v : 1'b1);
   assign br_target = BRsignal_ex ? fwd_b : pc_ex + (BR_to_shift_ex << 2);
   assign flush     = br_taken;

   // EX/MEM register; a stalled cycle inserts a bubble with no side effects
   always_ff @(posedge clk) begin
      if (reset) begin
         alu_mem       <= '0;
         wdata_mem     <= '0;
         Rd_mem        <= 5'd31;
         xfer_size_mem <= '0;
         MemtoReg_mem  <= 1'b0;
         RegWrite_mem  <= 1'b0;
         MemWrite_mem  <= 1'b0;
      end else begin
         alu_mem       <= res;
         wdata_mem     <= fwd_b;
         Rd_mem        <= stall ? 5'd31 : Rd_ex;
         xfer_size_mem <= xfer_size_ex;
         MemtoReg_mem  <= MemtoReg_ex & ~stall;
         RegWrite_mem  <= RegWrite_ex & ~stall;
         MemWrite_mem  <= MemWrite_ex & ~stall;
      end
   end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: scoreboard bench for ex_stage (EX_MUL_EN enables multiplier tests)
module tb_ex_stage;
   import cpu_pkg::*;
   localparam int DW = 64;
   logic          clk = 1'b0, reset;
   logic [DW-1:0] Da_ex, Db_ex, BR_to_shift_ex, pc_ex, ALU_or_DT_ex, wr_data_wb;
   logic [4:0]    Rd_ex, Ab_ex, Rn_ex, Rd_wb;
   logic [3:0]    xfer_size_ex;
   logic [2:0]    ALUop_ex;
   logic          cond_ex, ALUsrc_ex, MemtoReg_ex, RegWrite_ex, MemWrite_ex, cbz_ex, branch_ex, BRsignal_ex, update_ex, RegWrite_wb;
   logic [DW-1:0] alu_mem, wdata_mem, br_target;
   logic [4:0]    Rd_mem;
   logic [3:0]    xfer_size_mem;
   logic          MemtoReg_mem, RegWrite_mem, MemWrite_mem, br_taken, flush, stall;

   ex_stage #(.DW(DW), .MUL_CYCLES(64)) dut (
      .clk(clk), .reset(reset), .Da_ex(Da_ex), .Db_ex(Db_ex), .BR_to_shift_ex(BR_to_shift_ex),
      .pc_ex(pc_ex), .ALU_or_DT_ex(ALU_or_DT_ex), .Rd_ex(Rd_ex), .Ab_ex(Ab_ex), .Rn_ex(Rn_ex),
      .xfer_size_ex(xfer_size_ex), .ALUop_ex(ALUop_ex), .cond_ex(cond_ex), .ALUsrc_ex(ALUsrc_ex),
      .MemtoReg_ex(MemtoReg_ex), .RegWrite_ex(RegWrite_ex), .MemWrite_ex(MemWrite_ex), .cbz_ex(cbz_ex),
      .branch_ex(branch_ex), .BRsignal_ex(BRsignal_ex), .update_ex(update_ex), .wr_data_wb(wr_data_wb),
      .Rd_wb(Rd_wb), .RegWrite_wb(RegWrite_wb), .alu_mem(alu_mem), .wdata_mem(wdata_mem), .Rd_mem(Rd_mem),
      .xfer_size_mem(xfer_size_mem), .MemtoReg_mem(MemtoReg_mem), .RegWrite_mem(RegWrite_mem),
      .MemWrite_mem(MemWrite_mem), .br_taken(br_taken), .flush(flush), .br_target(br_target), .stall(stall)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0, failures = 0;

   typedef struct {
      int unsigned   at;
      string         name;
      logic          ca;
      logic [63:0]   alu;
      logic          cw;
      logic [63:0]   wdata;
      logic [4:0]    rd;
      logic          rw, mw, m2r;
      logic [3:0]    xs;
   } exp_t;
   exp_t q[$];
   exp_t mon_e;

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", n, act, exp);
      end
   endtask

   task automatic push(input string n, input int dly, input logic ca, input logic [63:0] a, input logic cw,
                       input logic [63:0] w, input logic [4:0] rd, input logic rw, input logic mw,
                       input logic m2r, input logic [3:0] xs);
      exp_t e;
      e.at = cyc + dly; e.name = n; e.ca = ca; e.alu = a; e.cw = cw; e.wdata = w;
      e.rd = rd; e.rw = rw; e.mw = mw; e.m2r = m2r; e.xs = xs;
      q.push_back(e);
   endtask

   task automatic nop();
      Da_ex = '0; Db_ex = '0; BR_to_shift_ex = '0; pc_ex = '0; ALU_or_DT_ex = '0; wr_data_wb = '0;
      Rd_ex = 5'd31; Ab_ex = 5'd31; Rn_ex = 5'd31; Rd_wb = 5'd31; xfer_size_ex = '0; ALUop_ex = ALU_PASSB;
      cond_ex = 0; ALUsrc_ex = 0; MemtoReg_ex = 0; RegWrite_ex = 0; MemWrite_ex = 0; cbz_ex = 0;
      branch_ex = 0; BRsignal_ex = 0; update_ex = 0; RegWrite_wb = 0;
   endtask

   // monitor: compare the EX/MEM outputs against the oldest expected entry due this cycle
   always @(posedge clk) begin
      #1;
      while (q.size() != 0 && q[0].at <= cyc) begin
         mon_e = q.pop_front();
         chk({mon_e.name, " cycle"}, 64'(cyc), 64'(mon_e.at));
         if (mon_e.ca) chk({mon_e.name, " alu_mem"}, alu_mem, mon_e.alu);
         if (mon_e.cw) chk({mon_e.name, " wdata_mem"}, wdata_mem, mon_e.wdata);
         chk({mon_e.name, " ctl"}, 64'({Rd_mem, RegWrite_mem, MemWrite_mem, MemtoReg_mem, xfer_size_mem}),
             64'({mon_e.rd, mon_e.rw, mon_e.mw, mon_e.m2r, mon_e.xs}));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   logic [2:0]  ops  [6] = '{ALU_AND, ALU_OR, ALU_XOR, ALU_SUB, ALU_PASSB, 3'b111};
   logic [63:0] lexp [6] = '{64'hF000, 64'hFFF0, 64'h0FF0, 64'hFFFF_FFFF_FFFF_F1F0, 64'hFF00, 64'hFF00};

   initial begin
      nop();
      reset = 1;
      repeat (2) @(negedge clk);
      chk("rst alu_mem", alu_mem, 0);
      chk("rst wdata_mem", wdata_mem, 0);
      chk("rst Rd_mem", 64'(Rd_mem), 31);
      chk("rst ctl", 64'({RegWrite_mem, MemWrite_mem, MemtoReg_mem}), 0);
      chk("rst stall", 64'(stall), 0);
      chk("rst flags", 64'(dut.flags_q), 0);
      reset = 0;
      nop(); Da_ex = 5; ALU_or_DT_ex = 7; ALUsrc_ex = 1; ALUop_ex = ALU_ADD; Rd_ex = 2; RegWrite_ex = 1;
      push("add", 1, 1, 12, 0, 0, 2, 1, 0, 0, 0);
      @(negedge clk);
      nop(); ALU_or_DT_ex = 64'h10; ALUsrc_ex = 1; Rd_ex = 3; RegWrite_ex = 1;
      push("movi x3", 1, 1, 64'h10, 0, 0, 3, 1, 0, 0, 0);
      @(negedge clk);
      nop(); Rn_ex = 3; ALU_or_DT_ex = 1; ALUsrc_ex = 1; ALUop_ex = ALU_ADD; Rd_ex = 4; RegWrite_ex = 1;
      Rd_wb = 3; wr_data_wb = 64'h99; RegWrite_wb = 1;
      push("fwd mem", 1, 1, 64'h11, 0, 0, 4, 1, 0, 0, 0);
      @(negedge clk);
      nop(); ALU_or_DT_ex = 64'h10; ALUsrc_ex = 1; Rd_ex = 31; RegWrite_ex = 1;
      push("movi x31", 1, 1, 64'h10, 0, 0, 31, 1, 0, 0, 0);
      @(negedge clk);
      nop(); Rn_ex = 3; ALU_or_DT_ex = 1; ALUsrc_ex = 1; ALUop_ex = ALU_ADD; Rd_ex = 4; RegWrite_ex = 1;
      Rd_wb = 3; wr_data_wb = 64'h99; RegWrite_wb = 1;
      push("fwd wb", 1, 1, 64'h9A, 0, 0, 4, 1, 0, 0, 0);
      @(negedge clk);
      nop(); Da_ex = 64'h100; ALU_or_DT_ex = 8; ALUsrc_ex = 1; ALUop_ex = ALU_ADD; Ab_ex = 5;
      Rd_wb = 5; wr_data_wb = 64'hABC; RegWrite_wb = 1; MemWrite_ex = 1; xfer_size_ex = 8;
      push("store", 1, 1, 64'h108, 1, 64'hABC, 31, 0, 1, 0, 8);
      @(negedge clk);
      nop(); Da_ex = 64'h200; ALU_or_DT_ex = 64'h10; ALUsrc_ex = 1; ALUop_ex = ALU_ADD; Rd_ex = 9;
      RegWrite_ex = 1; MemtoReg_ex = 1; xfer_size_ex = 4;
      push("load", 1, 1, 64'h210, 0, 0, 9, 1, 0, 1, 4);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         nop(); Da_ex = 64'hF0F0; Db_ex = 64'hFF00; ALUop_ex = ops[i]; Rd_ex = 5'(10 + i); RegWrite_ex = 1;
         push($sformatf("logic op%0d", ops[i]), 1, 1, lexp[i], 1, 64'hFF00, 5'(10 + i), 1, 0, 0, 0);
      end
`ifndef EX_MUL_EN
      @(negedge clk);
      nop(); Da_ex = 64'hF0F0; Db_ex = 64'hFF00; ALUop_ex = ALU_MUL; Rd_ex = 20; RegWrite_ex = 1;
      push("op001 passb", 1, 1, 64'hFF00, 0, 0, 20, 1, 0, 0, 0);
      #1 chk("op001 stall", 64'(stall), 0);
`endif
      @(negedge clk);
      nop(); Da_ex = 1; Db_ex = 2; ALUop_ex = ALU_SUB; update_ex = 1;
      push("subs 1-2", 1, 1, '1, 0, 0, 31, 0, 0, 0, 0);
      @(negedge clk);
      chk("flags 1-2", 64'(dut.flags_q), 64'b1000);
      nop(); branch_ex = 1; cond_ex = 1; pc_ex = 64'h40; BR_to_shift_ex = 3;
      #1 chk("blt taken", 64'(br_taken), 1);
      chk("blt target", br_target, 64'h4C);
      chk("blt flush", 64'(flush), 1);
      @(negedge clk);
      nop(); Da_ex = 2; Db_ex = 1; ALUop_ex = ALU_SUB; update_ex = 1;
      @(negedge clk);
      chk("flags 2-1", 64'(dut.flags_q), 64'b0010);
      nop(); branch_ex = 1; cond_ex = 1; pc_ex = 64'h40; BR_to_shift_ex = 3;
      #1 chk("blt not taken", 64'(br_taken), 0);
      chk("blt no flush", 64'(flush), 0);
      @(negedge clk);
      nop(); Da_ex = 64'h7FFF_FFFF_FFFF_FFFF; ALU_or_DT_ex = 1; ALUsrc_ex = 1; ALUop_ex = ALU_ADD;
      @(negedge clk);
      chk("flags no update", 64'(dut.flags_q), 64'b0010);
      update_ex = 1;
      @(negedge clk);
      chk("flags ovf", 64'(dut.flags_q), 64'b1001);
      nop(); branch_ex = 1; cond_ex = 1; pc_ex = 64'h40; BR_to_shift_ex = 3;
      #1 chk("blt n==v", 64'(br_taken), 0);
      @(negedge clk);
      nop(); Da_ex = 5; Db_ex = 5; ALUop_ex = ALU_SUB; update_ex = 1;
      @(negedge clk);
      chk("flags zero", 64'(dut.flags_q), 64'b0110);
      nop(); Da_ex = 64'hF0; Db_ex = 64'h0F; ALUop_ex = ALU_AND; update_ex = 1;
      @(negedge clk);
      chk("flags logic", 64'(dut.flags_q), 64'b0100);
      nop(); branch_ex = 1; cbz_ex = 1; Ab_ex = 7; Db_ex = 0; pc_ex = 64'h80; BR_to_shift_ex = '1 - 1;
      #1 chk("cbz taken", 64'(br_taken), 1);
      chk("cbz target", br_target, 64'h78);
      chk("cbz flush", 64'(flush), 1);
      @(negedge clk);
      Db_ex = 5;
      #1 chk("cbz not taken", 64'(br_taken), 0);
      chk("cbz no flush", 64'(flush), 0);
      @(negedge clk);
      Rd_wb = 7; wr_data_wb = 0; RegWrite_wb = 1;
      #1 chk("cbz fwd taken", 64'(br_taken), 1);
      @(negedge clk);
      nop(); branch_ex = 1; BRsignal_ex = 1; Ab_ex = 8; Db_ex = 64'h100; pc_ex = 64'h40;
      #1 chk("br taken", 64'(br_taken), 1);
      chk("br target", br_target, 64'h100);
      @(negedge clk);
      nop(); branch_ex = 1; pc_ex = 64'h1000; BR_to_shift_ex = 1;
      #1 chk("b target", br_target, 64'h1004);
      chk("b taken", 64'(br_taken), 1);
      branch_ex = 0;
      #1 chk("no branch", 64'(br_taken), 0);
`ifdef EX_MUL_EN
      @(negedge clk);
      nop(); Da_ex = 3; Db_ex = '1 - 3; ALUop_ex = ALU_MUL; Rd_ex = 7; RegWrite_ex = 1;
      for (int i = 1; i <= 65; i++) push("mul bubble", i, 0, 0, 0, 0, 31, 0, 0, 0, 0);
      push("mul result", 66, 1, 64'hFFFF_FFFF_FFFF_FFF4, 0, 0, 7, 1, 0, 0, 0);
      for (int i = 0; i < 65; i++) begin
         #1 chk("mul stall high", 64'(stall), 1);
         @(negedge clk);
      end
      #1 chk("mul stall low", 64'(stall), 0);
      @(negedge clk);
      nop(); Da_ex = 5; Db_ex = 6; ALUop_ex = ALU_MUL; Rd_ex = 8; RegWrite_ex = 1;
      repeat (10) @(negedge clk);
      reset = 1;
      nop();
      @(negedge clk);
      chk("mul rst stall", 64'(stall), 0);
      chk("mul rst state", 64'(dut.state), 64'(IDLE));
      chk("mul rst alu_mem", alu_mem, 0);
      chk("mul rst Rd_mem", 64'(Rd_mem), 31);
      chk("mul rst RegWrite", 64'(RegWrite_mem), 0);
      reset = 0;
`endif
      @(negedge clk);
      nop();
      for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
      chk("scoreboard drain", 64'(q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage pipelined CPU. It takes the ID/EX pipeline-register outputs and resolves operand forwarding, the ALU operation, branches, and the NZCV flags. It also contains the EX/MEM pipeline register and an optional iterative 64-bit multiplier that stalls the front end while it runs.

## Interface
- Parameters:
- DW, 64, datapath width
- MUL_CYCLES, 64, multiplier iterations (one bit per cycle)
- Ports:
- clk  in  1  rising-edge clock; the only clock
- reset  in  1  synchronous, active-high
- Da_ex, Db_ex, BR_to_shift_ex, pc_ex, ALU_or_DT_ex  in  DW  register operands, sign-extended branch offset, PC, sign-extended immediate
- Rd_ex, Ab_ex, Rn_ex  in  5  destination and source register numbers
- xfer_size_ex  in  4  / ALUop_ex  in  3  / cond_ex  in  1 (1 = B.LT)
- ALUsrc_ex, MemtoReg_ex, RegWrite_ex, MemWrite_ex, cbz_ex, branch_ex, BRsignal_ex, update_ex  in  1  control bits
- wr_data_wb  in  DW / Rd_wb  in  5 / RegWrite_wb  in  1  WB forwarding source
- alu_mem, wdata_mem  out  DW  registered ALU result and store data
- Rd_mem  out  5 / xfer_size_mem  out  4 / MemtoReg_mem, RegWrite_mem, MemWrite_mem  out  1  registered
- br_taken, flush  out  1 / br_target  out  DW  combinational
- stall  out  1  combinational; upstream holds PC, IF/ID and ID/EX while high

## Operation
- Forwarding, evaluated separately for Rn and Ab:
  - MEM (alu_mem/Rd_mem/RegWrite_mem) has priority over WB.
  - A source is forwarded only when its Rd matches the register number and Rd != 31.
  - Otherwise the value comes from Da_ex/Db_ex.
- Operand B = ALUsrc_ex ? ALU_or_DT_ex : fwd_b. Store data = fwd_b.
- ALUop encoding:
  - 000 pass B, 010 add, 011 sub, 100 and, 101 or, 110 xor.
  - 001 MUL (see Configuration).
  - 111 pass B.
- Arithmetic is DW-bit and wraps modulo 2^DW.
- Flags:
  - The NZCV register updates at the clock edge when update_ex=1 and stall=0.
  - N = result[DW-1]; Z = result==0.
  - C = carry out (sub: A + ~B + 1).
  - V = signed overflow.
  - C = V = 0 for logic and pass ops.
  - Reset value is 0000.
- Branch:
  - br_taken = branch_ex & (cbz_ex ? fwd_b==0 : cond_ex ? N!=V : 1).
  - B.LT reads the flags register. The flag-setting instruction has already passed EX, so no flag forwarding is needed.
  - br_target = BRsignal_ex ? fwd_b : pc_ex + (BR_to_shift_ex << 2).
  - flush = br_taken.
- EX/MEM register:
  - Captures every cycle when stall=0.
  - When stall=1 it captures a bubble: RegWrite_mem = MemWrite_mem = MemtoReg_mem = 0, Rd_mem = 31.

## Timing
- Non-MUL ops: one cycle. Operands are in EX in cycle n; results appear on the *_mem outputs after edge n.
- br_taken, br_target and flush are valid in the same cycle as EX.
- Reset: all registered outputs 0, Rd_mem = 31, flags 0000, multiplier FSM in IDLE. Reset aborts an in-flight multiply.
- Multiplier FSM (MUL_EN only):
  - IDLE: when ALUop_ex == 001, latch fwd_a and operand B, clear the accumulator, stall=1, go to BUSY.
  - BUSY: one shift-add step per cycle, stall=1. After MUL_CYCLES steps go to DONE.
  - DONE: stall=0, alu_mem captures the low DW bits of the product, go to IDLE.
  - Total stall is MUL_CYCLES+1 cycles; the MUL occupies EX for MUL_CYCLES+2 cycles.
  - MUL ignores update_ex.
  - Back-to-back MULs: the second enters IDLE on the cycle after DONE.
- Operands are latched in IDLE, so forwarding-source changes during the stall do not matter.

## Configuration
- EX_MUL_EN defined: the multiplier and its FSM are present; ALUop 001 = MUL, product low DW bits, signed and unsigned results identical.
- EX_MUL_EN undefined: no FSM; stall is tied to 0; ALUop 001 = pass B.

## Structure
- Shared package cpu_pkg holds:
  - the ALUop localparams (ALU_PASSB, ALU_MUL, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR)
  - the flags struct (n, z, c, v)
  - mul_state_t (IDLE, BUSY, DONE)
- One sub-module, alu_64: combinational result plus NZCV.
- The FSM, forwarding, flags and EX/MEM register live in ex_stage.

## Test plan
- ADD: Da=5, imm=7, ALUsrc=1, ALUop=010, Rd=2 -> next cycle alu_mem=12, RegWrite_mem=1, Rd_mem=2.
- Forwarding: MEM Rd=3 value 0x10, WB Rd=3 value 0x99, Rn=3, Da=0, add imm 1 -> alu_mem=0x11. Same case with Rd_mem=31 -> alu_mem=0x9A.
- SUBS 1−2 with update=1, then B.LT at pc=0x40, offset 3 -> flags N=1, Z=0, C=0, V=0; br_taken=1, br_target=0x4C, flush=1.
- CBZ: fwd_b=0 -> taken; fwd_b=5 -> br_taken=0, flush=0. BR with fwd_b=0x100 -> br_target=0x100.
- MUL (EX_MUL_EN): 3 × −4 -> stall high 65 cycles with bubbles on RegWrite_mem, then alu_mem=0xFFFF_FFFF_FFFF_FFF4.
- Reset during a multiply (cycle 10) -> stall=0 next cycle, FSM in IDLE, outputs zero, Rd_mem=31.
